// File: rtl/step_pkg.sv
// Shared constants for the half-step coil bus: pattern table, lockout periods,
// speed codes and decoder state types.
package step_pkg;

    localparam logic [3:0] HALF_STEP_PATTERN [8] = '{
        4'b1000, 4'b1010, 4'b0010, 4'b0110,
        4'b0100, 4'b0101, 4'b0001, 4'b1001
    };

    localparam int unsigned LOCKOUT [9] = '{
        333333, 285714, 250000, 222222, 200000,
        181818, 166666, 153846, 400000
    };

    localparam logic [3:0] UNKNOWN = 4'hF;

    typedef enum logic [3:0] {
        SPD_0       = 4'd0,
        SPD_1       = 4'd1,
        SPD_2       = 4'd2,
        SPD_3       = 4'd3,
        SPD_4       = 4'd4,
        SPD_5       = 4'd5,
        SPD_6       = 4'd6,
        SPD_7       = 4'd7,
        SPD_DEFAULT = 4'd8,
        SPD_UNKNOWN = UNKNOWN
    } speed_code_e;

    typedef enum logic {
        SYNC,
        TRACK
    } dec_state_e;

    typedef enum logic [1:0] {
        PAT_IDLE,
        PAT_VALID,
        PAT_ILLEGAL
    } pat_kind_e;

    typedef struct packed {
        pat_kind_e  kind;
        logic [2:0] idx;
    } pat_dec_t;

    function automatic pat_dec_t decode_pattern(logic [3:0] p);
        pat_dec_t d;
        d.kind = (p == 4'b0000) ? PAT_IDLE : PAT_ILLEGAL;
        d.idx  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (p == HALF_STEP_PATTERN[k]) begin
                d.kind = PAT_VALID;
                d.idx  = 3'(k);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Coil-bus reader interface: pattern and control pulses in, step status out.
interface step_phase_decoder_if #(
    parameter int POS_W = 32
);
    logic [3:0]              phase;
    logic                    zero_pos;
    logic                    clear_fault;
    logic                    step_pulse;
    logic                    dir;
    logic signed [POS_W-1:0] position;
    logic [31:0]             step_period;
    logic [3:0]              speed_code;
    logic                    moving;
    logic                    fault;

    modport master (
        output phase, zero_pos, clear_fault,
        input  step_pulse, dir, position, step_period,
        input  speed_code, moving, fault
    );

    modport slave (
        input  phase, zero_pos, clear_fault,
        output step_pulse, dir, position, step_period,
        output speed_code, moving, fault
    );
endinterface

// File: rtl/phase_sync_filter.sv
// Two-flop synchronizer for the coil pattern; with PHASE_FILTER_EN the pattern
// must also hold steady for FILTER_CYCLES samples before it is passed on.
module phase_sync_filter
    import step_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase_i,
    output logic [3:0] pattern_o
);
    logic [3:0] s1_q;
    logic [3:0] s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= phase_i;
            s2_q <= s1_q;
        end
    end

`ifdef PHASE_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [3:0]    cand_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    clean_q;

    // cnt_q counts consecutive samples of s2_q equal to cand_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q  <= 4'b0000;
            cnt_q   <= '0;
            clean_q <= 4'b0000;
        end else begin
            if (s2_q != cand_q) begin
                cand_q <= s2_q;
                cnt_q  <= CW'(1);
            end else if (cnt_q < CW'(FILTER_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (s2_q == cand_q && cnt_q >= CW'(FILTER_CYCLES - 1)) begin
                clean_q <= cand_q;
            end
        end
    end

    assign pattern_o = clean_q;
`else
    logic unused_filter;
    assign unused_filter = (FILTER_CYCLES == 0);
    assign pattern_o     = s2_q;
`endif

endmodule

// File: rtl/step_phase_decoder.sv
// Half-step coil bus reader: step/direction/position recovery, period and speed code.
// Optional glitch filter on the coil pattern via PHASE_FILTER_EN.
module step_phase_decoder
    import step_pkg::*;
#(
    parameter int          POS_W         = 32,
    parameter int unsigned SPEED_TOL     = 64,
    parameter int unsigned STALL_CYCLES  = 1_000_000,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned LOCKOUT_DIV   = 1
) (
    input logic           clk,
    input logic           rst,
    step_phase_decoder_if.slave bus
);
    logic [3:0] pattern;
    pat_dec_t   dec;
    logic [2:0] delta;
    logic [31:0] per_new;

    dec_state_e       state_q;
    logic [2:0]       anchor_q;
    logic             first_q;
    logic             step_q;
    logic             dir_q;
    logic [POS_W-1:0] pos_q;
    logic [31:0]      cnt_q;
    logic [31:0]      period_q;
    speed_code_e      speed_q;
    logic             moving_q;
    logic             fault_q;

    phase_sync_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .phase_i   (bus.phase),
        .pattern_o (pattern)
    );

    assign dec     = decode_pattern(pattern);
    assign delta   = dec.idx - anchor_q;
    assign per_new = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    // Lowest matching code wins; LOCKOUT_DIV scales the table for slower clocks
    function automatic speed_code_e classify(logic [31:0] p);
        logic [31:0] rv;
        logic [31:0] diff;
        classify = SPD_UNKNOWN;
        for (int k = 8; k >= 0; k--) begin
            rv   = LOCKOUT[k] / LOCKOUT_DIV + 32'd1;
            diff = (p >= rv) ? p - rv : rv - p;
            if (diff <= SPEED_TOL) classify = speed_code_e'(k[3:0]);
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SYNC;
            anchor_q <= 3'd0;
            first_q  <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            pos_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            speed_q  <= SPD_UNKNOWN;
            moving_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
            if (cnt_q >= 32'(STALL_CYCLES)) begin
                moving_q <= 1'b0;
                speed_q  <= SPD_UNKNOWN;
            end
            if (bus.clear_fault) fault_q <= 1'b0;

            unique case (state_q)
                SYNC: begin
                    case (dec.kind)
                        PAT_VALID: begin
                            anchor_q <= dec.idx;
                            first_q  <= 1'b1;
                            state_q  <= TRACK;
                        end
                        PAT_ILLEGAL: fault_q <= 1'b1;
                        default: ;
                    endcase
                end
                TRACK: begin
                    case (dec.kind)
                        PAT_IDLE: state_q <= SYNC;
                        PAT_ILLEGAL: begin
                            fault_q <= 1'b1;
                            state_q <= SYNC;
                        end
                        PAT_VALID: begin
                            anchor_q <= dec.idx;
                            unique case (1'b1)
                                (delta == 3'd0): ;
                                (delta == 3'd1),
                                (delta == 3'd7): begin
                                    step_q   <= 1'b1;
                                    dir_q    <= (delta == 3'd1);
                                    pos_q    <= (delta == 3'd1) ? pos_q + 1'b1
                                                                : pos_q - 1'b1;
                                    cnt_q    <= '0;
                                    moving_q <= 1'b1;
                                    first_q  <= 1'b0;
                                    if (!first_q) begin
                                        period_q <= per_new;
                                        speed_q  <= classify(per_new);
                                    end
                                end
                                default: fault_q <= 1'b1;
                            endcase
                        end
                        default: ;
                    endcase
                end
                default: state_q <= SYNC;
            endcase

            if (bus.zero_pos) pos_q <= '0;
        end
    end

    assign bus.step_pulse  = step_q;
    assign bus.dir         = dir_q;
    assign bus.position    = pos_q;
    assign bus.step_period = period_q;
    assign bus.speed_code  = speed_q;
    assign bus.moving      = moving_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder with a scaled lockout table.
// Covers stepping both ways, skip/illegal faults, stall, zero_pos, glitch, wrap, reset.
module tb_step_phase_decoder;
    localparam int          POS_W   = 32;
    localparam int unsigned TOL     = 4;
    localparam int unsigned STALL   = 2000;
    localparam int unsigned FILT    = 4;
    localparam int unsigned DIV     = 1000;
`ifdef PHASE_FILTER_EN
    localparam int LAT = 3 + FILT;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic [3:0] pat [8] = '{
        4'b1000, 4'b1010, 4'b0010, 4'b0110,
        4'b0100, 4'b0101, 4'b0001, 4'b1001
    };
    logic [31:0] pos_u;

    step_phase_decoder_if #(.POS_W(POS_W)) bus ();

    step_phase_decoder #(
        .POS_W         (POS_W),
        .SPEED_TOL     (TOL),
        .STALL_CYCLES  (STALL),
        .FILTER_CYCLES (FILT),
        .LOCKOUT_DIV   (DIV)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign pos_u = bus.position;

    always @(negedge clk) begin
        if (rst_n && bus.step_pulse) pulses++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] p, input int gap);
        @(negedge clk);
        bus.phase = p;
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        bus.phase       = 4'b0000;
        bus.zero_pos    = 1'b0;
        bus.clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pulse",  64'(bus.step_pulse),  64'd0);
        check("rst_dir",    64'(bus.dir),         64'd0);
        check("rst_pos",    64'(pos_u),           64'd0);
        check("rst_period", 64'(bus.step_period), 64'd0);
        check("rst_speed",  64'(bus.speed_code),  64'hF);
        check("rst_moving", 64'(bus.moving),      64'd0);
        check("rst_fault",  64'(bus.fault),       64'd0);
        rst_n = 1'b1;

        // forward stepping at the speed-2 period
        drive(pat[0], 251);
        for (int i = 1; i <= 16; i++) drive(pat[i % 8], 251);
        check("fwd_pulses", 64'(pulses),          64'd16);
        check("fwd_pos",    64'(pos_u),           64'd16);
        check("fwd_dir",    64'(bus.dir),         64'd1);
        check("fwd_period", 64'(bus.step_period), 64'd251);
        check("fwd_speed",  64'(bus.speed_code),  64'd2);
        check("fwd_moving", 64'(bus.moving),      64'd1);

        // reverse stepping at the speed-7 period
        for (int i = 1; i <= 10; i++) drive(pat[(64 - i) % 8], 154);
        check("rev_pulses", 64'(pulses),          64'd26);
        check("rev_pos",    64'(pos_u),           64'd6);
        check("rev_dir",    64'(bus.dir),         64'd0);
        check("rev_period", 64'(bus.step_period), 64'd154);
        check("rev_speed",  64'(bus.speed_code),  64'd7);

        // skipped step
        drive(pat[7], 154);
        drive(pat[0], 154);
        check("pre_skip_pos", 64'(pos_u), 64'd8);
        drive(4'b0110, 20);
        check("skip_fault",  64'(bus.fault), 64'd1);
        check("skip_pos",    64'(pos_u),     64'd8);
        check("skip_pulses", 64'(pulses),    64'd28);
        @(negedge clk);
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
        check("clr_fault", 64'(bus.fault), 64'd0);

        // illegal pattern forces resync
        drive(4'b1111, 20);
        check("ill_fault", 64'(bus.fault), 64'd1);
        drive(pat[0], 20);
        check("sync_pos",    64'(pos_u),  64'd8);
        check("sync_pulses", 64'(pulses), 64'd28);
        drive(pat[1], 20);
        check("resync_pos",    64'(pos_u),           64'd9);
        check("resync_dir",    64'(bus.dir),         64'd1);
        check("resync_period", 64'(bus.step_period), 64'd154);
        check("resync_speed",  64'(bus.speed_code),  64'd7);
        @(negedge clk);
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;

        // idle pattern resyncs without fault
        drive(4'b0000, 20);
        check("idle_fault", 64'(bus.fault), 64'd0);
        drive(pat[0], 20);
        check("idle_anchor_pos", 64'(pos_u), 64'd9);
        drive(pat[1], 20);
        check("idle_step_pos",    64'(pos_u),  64'd10);
        check("idle_step_pulses", 64'(pulses), 64'd30);

        // stall
        repeat (STALL + 20) @(negedge clk);
        check("stall_moving", 64'(bus.moving),     64'd0);
        check("stall_speed",  64'(bus.speed_code), 64'hF);

        // zero_pos coincident with a step, also checks latency
        @(negedge clk);
        bus.phase = pat[2];
        repeat (LAT - 1) @(negedge clk);
        check("lat_early", 64'(bus.step_pulse), 64'd0);
        bus.zero_pos = 1'b1;
        @(negedge clk);
        bus.zero_pos = 1'b0;
        check("lat_pulse",   64'(bus.step_pulse), 64'd1);
        check("zero_pos",    64'(pos_u),          64'd0);
        check("zero_moving", 64'(bus.moving),     64'd1);
        repeat (20) @(negedge clk);

        // 2-clk glitch 0010 -> 0110 -> 0010
        @(negedge clk);
        bus.phase = 4'b0110;
        repeat (2) @(negedge clk);
        bus.phase = pat[2];
        repeat (20) @(negedge clk);
`ifdef PHASE_FILTER_EN
        check("glitch_pulses", 64'(pulses), 64'd31);
`else
        check("glitch_pulses", 64'(pulses),  64'd33);
        check("glitch_dir",    64'(bus.dir), 64'd0);
`endif
        check("glitch_pos",   64'(pos_u),     64'd0);
        check("glitch_fault", 64'(bus.fault), 64'd0);

        // wrap below zero
        drive(pat[1], 20);
        check("wrap_pos", 64'(pos_u),   64'hFFFF_FFFF);
        check("wrap_dir", 64'(bus.dir), 64'd0);

        // reset mid-motion acts immediately
        #3 rst_n = 1'b0;
        #1;
        check("arst_pos",    64'(pos_u),           64'd0);
        check("arst_dir",    64'(bus.dir),         64'd0);
        check("arst_period", 64'(bus.step_period), 64'd0);
        check("arst_speed",  64'(bus.speed_code),  64'hF);
        check("arst_moving", 64'(bus.moving),      64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
